// File: rtl/endec_frame_packer.sv
// Packs per-cycle encoder symbols into one FRAME_SYMS x SYM_W frame for the Viterbi decoder.
// Optional channel-error emulation is enabled by defining ENDEC_PACKER_ERR_INJECT_EN.
module endec_frame_packer #(
    parameter int unsigned FRAME_SYMS = 128,
    parameter int unsigned SYM_W      = 3,
    parameter int unsigned CNT_W      = 8
) (
    input  logic                        sys_clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic                        i_code_rate,
    input  logic [SYM_W-1:0]            i_sym,
    input  logic                        i_sym_valid,
    output logic                        o_sym_ready,
    input  logic                        i_flush,
    output logic [FRAME_SYMS*SYM_W-1:0] o_frame,
    output logic                        o_frame_valid,
    input  logic                        i_frame_ready,
    output logic                        o_frame_rate,
    output logic [CNT_W-1:0]            o_sym_count
`ifdef ENDEC_PACKER_ERR_INJECT_EN
    ,
    input  logic [FRAME_SYMS*SYM_W-1:0] i_err_mask,
    input  logic                        i_err_en
`endif
);

    localparam int unsigned FRAME_W  = FRAME_SYMS * SYM_W;
    localparam int unsigned HALF_BIT = 2;
    localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(FRAME_SYMS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [FRAME_W-1:0]   frame_q, frame_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 rate_q, rate_d;
    logic                 valid_q, valid_d;
    logic                 ready_q, ready_d;

    logic                 accept;
    logic                 wr_en;
    logic [CNT_W-1:0]     wr_slot;
    logic [SYM_W-1:0]     wr_sym;

    // Rate 1/2 carries only two generator outputs; the third bit is stored as zero.
    function automatic logic [SYM_W-1:0] rate_mask(input logic [SYM_W-1:0] sym,
                                                   input logic             rate);
        logic [SYM_W-1:0] m;
        m = sym;
        if (!rate) begin
            m[HALF_BIT] = 1'b0;
        end
        return m;
    endfunction

    assign accept        = en & ready_q & i_sym_valid;
    assign o_sym_ready   = en & ready_q;
    assign o_frame       = frame_q;
    assign o_frame_valid = valid_q;
    assign o_frame_rate  = rate_q;
    assign o_sym_count   = cnt_q;

    // Next-state, frame write and handshake decode.
    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        cnt_d   = cnt_q;
        rate_d  = rate_q;
        wr_en   = 1'b0;
        wr_slot = cnt_q;
        wr_sym  = '0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    rate_d  = i_code_rate;
                    wr_en   = 1'b1;
                    wr_slot = '0;
                    cnt_d   = CNT_W'(1);
                    state_d = ((FRAME_SYMS == 1) || i_flush) ? HOLD : FILL;
                end
            end
            FILL: begin
                if (accept) begin
                    wr_en = 1'b1;
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if ((accept && (cnt_q == LAST_SLOT)) || i_flush) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (i_frame_ready) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    frame_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        wr_sym = rate_mask(i_sym, rate_d);
        if (wr_en) begin
            for (int unsigned k = 0; k < FRAME_SYMS; k++) begin
                if (CNT_W'(k) == wr_slot) begin
                    frame_d[SYM_W*k +: SYM_W] = wr_sym;
                end
            end
        end

`ifdef ENDEC_PACKER_ERR_INJECT_EN
        // Errors are applied once, as the frame closes, and never light a rate-1/2 pad bit.
        if ((state_q != HOLD) && (state_d == HOLD) && i_err_en) begin
            frame_d = frame_d ^ i_err_mask;
            if (!rate_d) begin
                for (int unsigned k = 0; k < FRAME_SYMS; k++) begin
                    frame_d[SYM_W*k + HALF_BIT] = 1'b0;
                end
            end
        end
`endif

        // Ready is taken from the current state so a handoff leaves one bubble cycle.
        ready_d = (state_q != HOLD) && (state_d != HOLD);
        valid_d = (state_d == HOLD);
    end

    // State and datapath registers; everything holds while en is low.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q <= IDLE;
            frame_q <= '0;
            cnt_q   <= '0;
            rate_q  <= 1'b0;
            valid_q <= 1'b0;
            ready_q <= 1'b0;
        end else if (en) begin
            state_q <= state_d;
            frame_q <= frame_d;
            cnt_q   <= cnt_d;
            rate_q  <= rate_d;
            valid_q <= valid_d;
            ready_q <= ready_d;
        end
    end

endmodule

// File: tb/tb_endec_frame_packer.sv
// Self-checking bench for endec_frame_packer: vector table, scoreboard queue and corner sequences.
// Error-injection checks are built when ENDEC_PACKER_ERR_INJECT_EN is defined.
module tb_endec_frame_packer;

    localparam int unsigned FS = 128;
    localparam int unsigned SW = 3;
    localparam int unsigned CW = 8;
    localparam int unsigned FW = FS * SW;

    logic            sys_clk = 1'b0;
    logic            rst;
    logic            en;
    logic            i_code_rate;
    logic [SW-1:0]   i_sym;
    logic            i_sym_valid;
    logic            o_sym_ready;
    logic            i_flush;
    logic [FW-1:0]   o_frame;
    logic            o_frame_valid;
    logic            i_frame_ready;
    logic            o_frame_rate;
    logic [CW-1:0]   o_sym_count;
`ifdef ENDEC_PACKER_ERR_INJECT_EN
    logic [FW-1:0]   i_err_mask;
    logic            i_err_en;
`endif

    endec_frame_packer #(.FRAME_SYMS(FS), .SYM_W(SW), .CNT_W(CW)) dut (
        .sys_clk       (sys_clk),
        .rst           (rst),
        .en            (en),
        .i_code_rate   (i_code_rate),
        .i_sym         (i_sym),
        .i_sym_valid   (i_sym_valid),
        .o_sym_ready   (o_sym_ready),
        .i_flush       (i_flush),
        .o_frame       (o_frame),
        .o_frame_valid (o_frame_valid),
        .i_frame_ready (i_frame_ready),
        .o_frame_rate  (o_frame_rate),
        .o_sym_count   (o_sym_count)
`ifdef ENDEC_PACKER_ERR_INJECT_EN
        ,
        .i_err_mask    (i_err_mask),
        .i_err_en      (i_err_en)
`endif
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [FW-1:0] frame;
        logic          rate;
        logic [CW-1:0] cnt;
    } exp_t;

    typedef struct {
        logic          rate;
        logic [SW-1:0] sym;
        logic [SW-1:0] exp_slot;
    } vec_t;

    exp_t          sb[$];
    int            total = 0;
    int            bad   = 0;
    logic [FW-1:0] m_frame;
    int            m_cnt;
    logic          m_rate;

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic push_exp();
        exp_t e;
        e.frame = m_frame;
        e.rate  = m_rate;
        e.cnt   = CW'(m_cnt);
`ifdef ENDEC_PACKER_ERR_INJECT_EN
        if (i_err_en) begin
            e.frame = e.frame ^ i_err_mask;
            if (!m_rate) begin
                for (int k = 0; k < FS; k++) e.frame[SW*k + 2] = 1'b0;
            end
        end
`endif
        sb.push_back(e);
        m_frame = '0;
        m_cnt   = 0;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!o_sym_ready && n < 50) begin
            step();
            n++;
        end
        check("ready_timeout", o_sym_ready, 1);
    endtask

    // Drive one symbol and update the reference model; a closed frame goes to the scoreboard.
    task automatic send(input logic [SW-1:0] sym, input logic rate, input logic flush);
        wait_ready();
        i_sym       = sym;
        i_code_rate = rate;
        i_sym_valid = 1'b1;
        i_flush     = flush;
        if (m_cnt == 0) m_rate = rate;
        m_frame[SW*m_cnt +: SW] = m_rate ? sym : (sym & 3'b011);
        m_cnt++;
        if (m_cnt == FS || flush) push_exp();
        step();
        i_sym_valid = 1'b0;
        i_flush     = 1'b0;
    endtask

    task automatic get_frame(input string nm);
        exp_t e;
        int   n = 0;
        while (!o_frame_valid && n < 300) begin
            step();
            n++;
        end
        check({nm, "_valid_timeout"}, o_frame_valid, 1);
        check({nm, "_sb_nonempty"}, sb.size() != 0, 1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({nm, "_frame"}, o_frame, e.frame);
            check({nm, "_rate"}, o_frame_rate, e.rate);
            check({nm, "_count"}, o_sym_count, e.cnt);
        end
        check({nm, "_ready_held"}, o_sym_ready, 0);
        i_frame_ready = 1'b1;
        step();
        i_frame_ready = 1'b0;
        check({nm, "_valid_drop"}, o_frame_valid, 0);
        check({nm, "_bubble"}, o_sym_ready, 0);
        check({nm, "_count_clr"}, o_sym_count, 0);
        check({nm, "_frame_clr"}, o_frame, 0);
        step();
        check({nm, "_ready_back"}, o_sym_ready, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t          vecs[6];
        logic [FW-1:0] held;
        vecs[0] = '{rate: 1'b1, sym: 3'b101, exp_slot: 3'b101};
        vecs[1] = '{rate: 1'b1, sym: 3'b111, exp_slot: 3'b111};
        vecs[2] = '{rate: 1'b0, sym: 3'b111, exp_slot: 3'b011};
        vecs[3] = '{rate: 1'b0, sym: 3'b100, exp_slot: 3'b000};
        vecs[4] = '{rate: 1'b0, sym: 3'b010, exp_slot: 3'b010};
        vecs[5] = '{rate: 1'b1, sym: 3'b000, exp_slot: 3'b000};

        rst = 1'b1; en = 1'b1; i_code_rate = 1'b0; i_sym = '0; i_sym_valid = 1'b0;
        i_flush = 1'b0; i_frame_ready = 1'b0;
`ifdef ENDEC_PACKER_ERR_INJECT_EN
        i_err_mask = '0; i_err_en = 1'b0;
`endif
        m_frame = '0; m_cnt = 0; m_rate = 1'b0;

        // Reset state
        step(); step();
        check("rst_frame", o_frame, 0);
        check("rst_valid", o_frame_valid, 0);
        check("rst_ready", o_sym_ready, 0);
        check("rst_rate", o_frame_rate, 0);
        check("rst_count", o_sym_count, 0);
        rst = 1'b0;
        step();
        check("post_rst_ready", o_sym_ready, 1);

        // Single-symbol frames closed by flush-with-accept in IDLE
        for (int i = 0; i < 6; i++) begin
            send(vecs[i].sym, vecs[i].rate, 1'b1);
            check("vec_latency", o_frame_valid, 1);
            check("vec_slot0", o_frame[2:0], vecs[i].exp_slot);
            get_frame("vec");
        end

        // Full rate-1/3 frame, then backpressure with symbols offered
        for (int k = 0; k < FS; k++) send(SW'(k), 1'b1, 1'b0);
        check("full_latency", o_frame_valid, 1);
        held = (sb.size() != 0) ? sb[0].frame : '0;
        for (int i = 0; i < 20; i++) begin
            i_sym_valid = 1'b1;
            i_sym       = 3'b010;
            step();
            check("bp_frame", o_frame, held);
            check("bp_ready", o_sym_ready, 0);
            check("bp_count", o_sym_count, CW'(FS));
        end
        i_sym_valid = 1'b0;
        get_frame("full13");

        // Rate 1/2 masking with a mid-frame rate change
        for (int k = 0; k < FS; k++) send(3'b111, (k >= 60) ? 1'b1 : 1'b0, 1'b0);
        check("half_slot127", o_frame[FW-1 -: SW], 3'b011);
        get_frame("half");

        // Flush together with the 6th symbol
        for (int k = 0; k < 5; k++) send(3'b101, 1'b1, 1'b0);
        send(3'b101, 1'b1, 1'b1);
        check("flush6_count", o_sym_count, 6);
        get_frame("flush6");

        // Flush in FILL without an accept
        for (int k = 0; k < 3; k++) send(3'b110, 1'b0, 1'b0);
        i_flush = 1'b1;
        step();
        i_flush = 1'b0;
        push_exp();
        get_frame("flush3");

        // Flush in IDLE with no accept emits nothing
        i_flush = 1'b1;
        step();
        i_flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("idle_flush_novalid", o_frame_valid, 0);
            check("idle_flush_count", o_sym_count, 0);
        end

        // Reset at symbol 70 discards the partial frame
        for (int k = 0; k < 70; k++) send(SW'(k), 1'b1, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        m_frame = '0; m_cnt = 0;
        check("midrst_frame", o_frame, 0);
        check("midrst_count", o_sym_count, 0);
        check("midrst_rate", o_frame_rate, 0);
        check("midrst_valid", o_frame_valid, 0);
        send(3'b110, 1'b1, 1'b1);
        get_frame("after_rst");

        // Enable low mid-frame freezes everything
        for (int k = 0; k < 10; k++) send(SW'(k + 3), 1'b1, 1'b0);
        en = 1'b0;
        i_sym_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check("en_count", o_sym_count, 10);
            check("en_ready", o_sym_ready, 0);
            check("en_valid", o_frame_valid, 0);
        end
        i_sym_valid = 1'b0;
        en = 1'b1;
        for (int k = 10; k < FS; k++) send(SW'(k + 3), 1'b1, 1'b0);
        get_frame("en_frame");

`ifdef ENDEC_PACKER_ERR_INJECT_EN
        begin
            logic [FW-1:0] ev;
            ev = '0;
            ev[0] = 1'b1;
            ev[FW-1] = 1'b1;
            i_err_mask = ev;
            i_err_en   = 1'b1;
            for (int k = 0; k < FS; k++) send(3'b000, 1'b1, 1'b0);
            check("err_bits", o_frame, ev);
            get_frame("err");
            i_err_en = 1'b0;
        end
`endif

        check("sb_drained", sb.size() == 0, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
